// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths,
// the reset fetch address, the NOP encoding and the output-register
// source selector.
package if_stage_pkg;

   localparam int          IMEM_DWIDTH  = 32;
   localparam int          PC_WIDTH_DEF = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] INST_NOP     = 32'h0000_0013;

   // Where the decode-facing output register takes its next value from.
   typedef enum logic [1:0] {
      OUT_HOLD  = 2'd0,
      OUT_FLUSH = 2'd1,
      OUT_SKID  = 2'd2,
      OUT_BEAT  = 2'd3
   } out_sel_e;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer that catches the memory beat which arrives while
// decode is stalled. flush wins over wr and rd.
module fetch_skid
   import if_stage_pkg::*;
#(
   parameter int DWIDTH   = IMEM_DWIDTH,
   parameter int PC_WIDTH = PC_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                wr,
   input  logic                rd,
   input  logic [DWIDTH-1:0]   wr_inst,
   input  logic [PC_WIDTH-1:0] wr_pc,
   output logic                valid,
   output logic [DWIDTH-1:0]   inst,
   output logic [PC_WIDTH-1:0] pc
);

   // Occupancy flag: a write fills the entry, a read or a flush empties it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (wr) begin
         valid <= 1'b1;
      end else if (rd) begin
         valid <= 1'b0;
      end
   end

   // Payload capture; contents are only meaningful while valid is set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst <= DWIDTH'(INST_NOP);
         pc   <= '0;
      end else if (wr && !flush) begin
         inst <= wr_inst;
         pc   <= wr_pc;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one request per cycle
// to a one-cycle-latency instruction memory, and presents a registered
// {inst, pc, valid} to decode. A one-entry skid absorbs the single beat
// still in flight when decode stalls; a redirect flushes everything.
module if_stage
   import if_stage_pkg::*;
#(
   parameter int                DWIDTH   = IMEM_DWIDTH,
   parameter int                PC_WIDTH = PC_WIDTH_DEF,
   parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(RESET_PC_DEF)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   output logic                imem_en,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic [DWIDTH-1:0]   imem_rdata,
   output logic [DWIDTH-1:0]   inst_out,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic                valid_out
);

   logic [PC_WIDTH-1:0] pc_f;
   logic [PC_WIDTH-1:0] redirect_pc_al;
   logic                req_valid_q;
   logic [PC_WIDTH-1:0] req_pc_q;

   logic                skid_valid;
   logic [DWIDTH-1:0]   skid_inst;
   logic [PC_WIDTH-1:0] skid_pc;
   logic                skid_wr;
   logic                skid_rd;

   logic                issue;
   logic                accept;
   out_sel_e            out_sel;

   // Fetch only when nothing is pending a flush and decode can take more.
   // Holding off during a stall leaves at most one beat (the skid's) in flight.
   assign issue     = !rst && !redirect_valid && !stall;
   assign imem_en   = issue;
   assign imem_addr = pc_f;

   assign redirect_pc_al = redirect_pc & ~PC_WIDTH'(2'b11);

   assign accept  = !stall || !valid_out;
   assign skid_wr = !redirect_valid && !accept && req_valid_q;
   assign skid_rd = (out_sel == OUT_SKID);

   // Output-register source: redirect flushes, otherwise a buffered beat
   // goes ahead of the one arriving from memory.
   always_comb begin
      out_sel = OUT_HOLD;
      if (redirect_valid) begin
         out_sel = OUT_FLUSH;
      end else if (accept) begin
         out_sel = skid_valid ? OUT_SKID : OUT_BEAT;
      end
   end

   // Fetch PC and the tracker describing next cycle's memory beat.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_f        <= RESET_PC;
         req_valid_q <= 1'b0;
         req_pc_q    <= '0;
      end else if (redirect_valid) begin
         pc_f        <= redirect_pc_al;
         req_valid_q <= 1'b0;
      end else if (issue) begin
         pc_f        <= pc_f + PC_WIDTH'(3'd4);
         req_valid_q <= 1'b1;
         req_pc_q    <= pc_f;
      end else begin
         req_valid_q <= 1'b0;
      end
   end

   fetch_skid #(
      .DWIDTH   (DWIDTH),
      .PC_WIDTH (PC_WIDTH)
   ) u_fetch_skid (
      .clk     (clk),
      .rst     (rst),
      .flush   (redirect_valid),
      .wr      (skid_wr),
      .rd      (skid_rd),
      .wr_inst (imem_rdata),
      .wr_pc   (req_pc_q),
      .valid   (skid_valid),
      .inst    (skid_inst),
      .pc      (skid_pc)
   );

   // Decode-facing output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_out  <= DWIDTH'(INST_NOP);
         pc_out    <= '0;
         valid_out <= 1'b0;
      end else begin
         unique case (out_sel)
            OUT_FLUSH: begin
               inst_out  <= DWIDTH'(INST_NOP);
               valid_out <= 1'b0;
            end
            OUT_SKID: begin
               inst_out  <= skid_inst;
               pc_out    <= skid_pc;
               valid_out <= 1'b1;
            end
            OUT_BEAT: begin
               inst_out  <= imem_rdata;
               pc_out    <= req_pc_q;
               valid_out <= req_valid_q;
            end
            default: begin
            end
         endcase
      end
   end

   // A beat can only arrive after an issue, and issue needs stall low the
   // cycle before, which would already have drained the skid.
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(req_valid_q && skid_valid && accept));
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a one-cycle synchronous memory model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] inst_out;
   logic [31:0] pc_out;
   logic        valid_out;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   if_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_en        (imem_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .inst_out       (inst_out),
      .pc_out         (pc_out),
      .valid_out      (valid_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A3C_0000;
   endfunction

   // Memory returns data the cycle after a request; idle cycles return junk.
   always @(posedge clk) begin
      imem_rdata <= imem_en ? mem_word(imem_addr) : 32'hDEAD_BEEF;
   end

   task automatic do_reset;
      rst = 1'b1;
      stall = 1'b0;
      redirect_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid_out); end
      checks++; if (inst_out !== NOP) begin errors++; $display("FAIL reset_inst: got %h exp %h", inst_out, NOP); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", pc_out); end
      checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b exp 0", imem_en); end
   endtask

   // Leaves the DUT in cycle 10 (pc_out = 0x20, imem_addr = 0x28).
   task automatic test_sequential;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL seq_en c%0d: got %b exp 1", c, imem_en); end
         checks++; if (imem_addr !== 32'(4*c)) begin errors++; $display("FAIL seq_addr c%0d: got %h exp %h", c, imem_addr, 32'(4*c)); end
         if (c >= 2) begin
            checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL seq_valid c%0d: got %b exp 1", c, valid_out); end
            checks++; if (pc_out !== 32'(4*(c-2))) begin errors++; $display("FAIL seq_pc c%0d: got %h exp %h", c, pc_out, 32'(4*(c-2))); end
            checks++; if (inst_out !== mem_word(32'(4*(c-2)))) begin errors++; $display("FAIL seq_inst c%0d: got %h exp %h", c, inst_out, mem_word(32'(4*(c-2)))); end
         end else begin
            checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL seq_startup_valid c%0d: got %b exp 0", c, valid_out); end
         end
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_stall;
      stall = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL stall_en k%0d: got %b exp 0", k, imem_en); end
         checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stall_valid k%0d: got %b exp 1", k, valid_out); end
         checks++; if (pc_out !== 32'h20) begin errors++; $display("FAIL stall_pc_hold k%0d: got %h exp 20", k, pc_out); end
         checks++; if (inst_out !== mem_word(32'h20)) begin errors++; $display("FAIL stall_inst_hold k%0d: got %h exp %h", k, inst_out, mem_word(32'h20)); end
         @(negedge clk);
      end
      stall = 1'b0;
      #1;
      for (int k = 0; k < 6; k++) begin
         checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL resume_en k%0d: got %b exp 1", k, imem_en); end
         checks++; if (imem_addr !== 32'(40 + 4*k)) begin errors++; $display("FAIL resume_addr k%0d: got %h exp %h", k, imem_addr, 32'(40 + 4*k)); end
         checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL resume_valid k%0d: got %b exp 1", k, valid_out); end
         checks++; if (pc_out !== 32'(32 + 4*k)) begin errors++; $display("FAIL resume_pc k%0d: got %h exp %h", k, pc_out, 32'(32 + 4*k)); end
         checks++; if (inst_out !== mem_word(32'(32 + 4*k))) begin errors++; $display("FAIL resume_inst k%0d: got %h exp %h", k, inst_out, mem_word(32'(32 + 4*k))); end
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_redirect;
      do_reset();
      repeat (4) @(negedge clk);
      checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL redir_pre_addr: got %h exp 10", imem_addr); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h100;
      #1;
      checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL redir_en_t: got %b exp 0", imem_en); end
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL redir_valid_t1: got %b exp 0", valid_out); end
      checks++; if (inst_out !== NOP) begin errors++; $display("FAIL redir_nop_t1: got %h exp %h", inst_out, NOP); end
      checks++; if (imem_en !== 1'b1) begin errors++; $display("FAIL redir_en_t1: got %b exp 1", imem_en); end
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr_t1: got %h exp 100", imem_addr); end
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL redir_valid_t2: got %b exp 0", valid_out); end
      checks++; if (imem_addr !== 32'h104) begin errors++; $display("FAIL redir_addr_t2: got %h exp 104", imem_addr); end
      @(negedge clk);
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL redir_valid_t3: got %b exp 1", valid_out); end
      checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL redir_pc_t3: got %h exp 100", pc_out); end
      checks++; if (inst_out !== mem_word(32'h100)) begin errors++; $display("FAIL redir_inst_t3: got %h exp %h", inst_out, mem_word(32'h100)); end
      @(negedge clk);
      checks++; if (pc_out !== 32'h104) begin errors++; $display("FAIL redir_pc_t4: got %h exp 104", pc_out); end
   endtask

   task automatic test_redirect_stall;
      do_reset();
      repeat (4) @(negedge clk);
      stall = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (pc_out !== 32'h8) begin errors++; $display("FAIL rs_hold_pc: got %h exp 8", pc_out); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h200;
      #1;
      checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL rs_en_t: got %b exp 0", imem_en); end
      @(negedge clk);
      redirect_valid = 1'b0;
      stall = 1'b0;
      #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rs_valid_t1: got %b exp 0", valid_out); end
      checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rs_addr_t1: got %h exp 200", imem_addr); end
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rs_skid_flushed: got %b pc %h exp valid 0", valid_out, pc_out); end
      @(negedge clk);
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL rs_valid_t3: got %b exp 1", valid_out); end
      checks++; if (pc_out !== 32'h200) begin errors++; $display("FAIL rs_pc_t3: got %h exp 200", pc_out); end
   endtask

   task automatic test_wrap_align;
      do_reset();
      repeat (3) @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h exp fffffffc", imem_addr); end
      @(negedge clk);
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h exp 0", imem_addr); end
      @(negedge clk);
      checks++; if (pc_out !== 32'hFFFF_FFFC || valid_out !== 1'b1) begin errors++; $display("FAIL wrap_pc0: got %h/%b exp fffffffc/1", pc_out, valid_out); end
      @(negedge clk);
      checks++; if (pc_out !== 32'h0 || inst_out !== mem_word(32'h0)) begin errors++; $display("FAIL wrap_pc1: got %h/%h exp 0/%h", pc_out, inst_out, mem_word(32'h0)); end
      redirect_valid = 1'b1;
      redirect_pc = 32'h103;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL align_addr: got %h exp 100", imem_addr); end
      repeat (2) @(negedge clk);
      checks++; if (pc_out !== 32'h100 || valid_out !== 1'b1) begin errors++; $display("FAIL align_pc: got %h/%b exp 100/1", pc_out, valid_out); end
   endtask

   task automatic test_async_reset;
      do_reset();
      repeat (5) @(negedge clk);
      stall = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b exp 0", valid_out); end
      checks++; if (inst_out !== NOP) begin errors++; $display("FAIL arst_inst: got %h exp %h", inst_out, NOP); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL arst_pc: got %h exp 0", pc_out); end
      checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL arst_en: got %b exp 0", imem_en); end
      stall = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL arst_restart: got %b/%h exp 1/0", imem_en, imem_addr); end
      @(negedge clk);
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL arst_stale_skid: got %b pc %h exp valid 0", valid_out, pc_out); end
      @(negedge clk);
      checks++; if (valid_out !== 1'b1 || pc_out !== 32'h0) begin errors++; $display("FAIL arst_first: got %b/%h exp 1/0", valid_out, pc_out); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_redirect_stall();
      test_wrap_align();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
